tfe_ingress_sched: RTL and testbench

- Shares one TFE_top instance between NUM_PORTS ingress requesters. Each requester presents one packet: a 104-bit 5-tuple plus a 256-bit raw feature.
- Arbitrates round-robin, enforces a minimum issue gap to avoid hash-table read-modify-write hazards, and drives the TFE ip_* inputs from registers.
- Carries the source-port tag down a delay line matched to TFE result latency, so downstream logic knows which port each o_hash/o_feature belongs to.

---
 rtl/tfe_pkg.sv | 20 ++
 rtl/tfe_rr_arbiter.sv | 36 +++
 rtl/tfe_ingress_sched.sv | 123 ++++++++++++
 tb/tb_tfe_ingress_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tfe_pkg.sv
// Shared types and constants for the TFE ingress scheduler slice.
package tfe_pkg;

  localparam int unsigned TUPLE_W     = 104;
  localparam int unsigned FEAT_W      = 256;
  localparam int unsigned HASH_W      = 16;
  localparam int unsigned TFE_LAT_DEF = 4;
  localparam int unsigned GAP_W       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  typedef struct packed {
    logic [TUPLE_W-1:0] tuple;
    logic [FEAT_W-1:0]  feature;
  } pkt_t;

endpackage

// File: rtl/tfe_rr_arbiter.sv
// Combinational round-robin grant: first request searching upward from ptr+1, wrapping.
module tfe_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  int unsigned      idx;
  logic [IDX_W-1:0] sel;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    if (en) begin
      for (int unsigned i = 1; i <= N; i++) begin
        idx = (32'(ptr) + i) % N;
        sel = IDX_W'(idx);
        if (!found && req[sel]) begin
          found      = 1'b1;
          grant[sel] = 1'b1;
          grant_idx  = sel;
        end
      end
    end
  end

endmodule

// File: rtl/tfe_ingress_sched.sv
// Round-robin scheduler sharing one TFE between ingress ports, with issue-gap
// enforcement and a source-port tag line aligned to TFE result latency.
module tfe_ingress_sched
  import tfe_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned PORT_W    = 2,
  parameter int unsigned TFE_LAT   = TFE_LAT_DEF,
  parameter int unsigned ISSUE_GAP = 0,
  parameter int unsigned CNT_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           stall,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS*TUPLE_W-1:0]   req_tuple,
  input  logic [NUM_PORTS*FEAT_W-1:0]    req_feature,
  output logic [NUM_PORTS-1:0]           req_ready,
  output logic [TUPLE_W-1:0]             tfe_ip_tuple,
  output logic [FEAT_W-1:0]              tfe_raw_feature,
  output logic                           tfe_ip_valid,
  output logic [PORT_W-1:0]              tag_port,
  output logic                           tag_valid,
  output logic [CNT_W-1:0]               in_flight
);

  state_t               state;
  logic [GAP_W-1:0]     gap_cnt;
  logic [PORT_W-1:0]    rr_ptr;
  logic [PORT_W-1:0]    grant_idx;
  logic [NUM_PORTS-1:0] grant;
  logic                 eligible_c;
  logic                 transfer_c;
  pkt_t                 pkt_sel;

  logic                 tag_v_q [TFE_LAT];
  logic [PORT_W-1:0]    tag_p_q [TFE_LAT];

  assign eligible_c = en & ~stall & (state == IDLE) & (|req_valid);

  tfe_rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (PORT_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (eligible_c),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready        = grant;
  assign transfer_c       = |(req_valid & grant);
  assign pkt_sel.tuple    = req_tuple[32'(grant_idx)*TUPLE_W +: TUPLE_W];
  assign pkt_sel.feature  = req_feature[32'(grant_idx)*FEAT_W +: FEAT_W];

  // Issue register and gap FSM; gap_cnt runs regardless of en/stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      gap_cnt         <= '0;
      rr_ptr          <= PORT_W'(NUM_PORTS - 1);
      tfe_ip_valid    <= 1'b0;
      tfe_ip_tuple    <= '0;
      tfe_raw_feature <= '0;
    end else begin
      tfe_ip_valid <= transfer_c;
      if (transfer_c) begin
        rr_ptr          <= grant_idx;
        tfe_ip_tuple    <= pkt_sel.tuple;
        tfe_raw_feature <= pkt_sel.feature;
      end
      case (state)
        IDLE: begin
          if (transfer_c && (ISSUE_GAP > 0)) begin
            state   <= GAP;
            gap_cnt <= GAP_W'(ISSUE_GAP);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag line fed from the issue register so the last stage lines up with o_hash_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TFE_LAT; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_p_q[i] <= '0;
      end
    end else begin
      tag_v_q[0] <= tfe_ip_valid;
      tag_p_q[0] <= rr_ptr;
      for (int unsigned i = 1; i < TFE_LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_p_q[i] <= tag_p_q[i-1];
      end
    end
  end

  assign tag_valid = tag_v_q[TFE_LAT-1];
  assign tag_port  = tag_p_q[TFE_LAT-1];

  // Outstanding-result counter, saturating at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
    end else begin
      case ({tfe_ip_valid, tag_valid})
        2'b10: if (in_flight != '1) in_flight <= in_flight + CNT_W'(1);
        2'b01: if (in_flight != '0) in_flight <= in_flight - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tfe_ingress_sched.sv
// Directed bench for tfe_ingress_sched: main instance (no gap) plus a gap-2 instance.
module tb_tfe_ingress_sched;
  import tfe_pkg::*;

  localparam int unsigned NP = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic                  stall;
  logic [NP-1:0]         req_valid;
  logic [NP-1:0]         g_req_valid;
  logic [NP*TUPLE_W-1:0] req_tuple;
  logic [NP*FEAT_W-1:0]  req_feature;

  logic [NP-1:0]      req_ready,    g_req_ready;
  logic [TUPLE_W-1:0] tfe_ip_tuple, g_tfe_ip_tuple;
  logic [FEAT_W-1:0]  tfe_raw_feature, g_tfe_raw_feature;
  logic               tfe_ip_valid, g_tfe_ip_valid;
  logic [1:0]         tag_port, g_tag_port;
  logic               tag_valid, g_tag_valid;
  logic [3:0]         in_flight, g_in_flight;

  int n_cmp = 0;
  int n_err = 0;

  tfe_ingress_sched #(.NUM_PORTS(4), .PORT_W(2), .TFE_LAT(4), .ISSUE_GAP(0), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
    .req_valid(req_valid), .req_tuple(req_tuple), .req_feature(req_feature),
    .req_ready(req_ready), .tfe_ip_tuple(tfe_ip_tuple), .tfe_raw_feature(tfe_raw_feature),
    .tfe_ip_valid(tfe_ip_valid), .tag_port(tag_port), .tag_valid(tag_valid),
    .in_flight(in_flight)
  );

  tfe_ingress_sched #(.NUM_PORTS(4), .PORT_W(2), .TFE_LAT(4), .ISSUE_GAP(2), .CNT_W(4)) dut_gap (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
    .req_valid(g_req_valid), .req_tuple(req_tuple), .req_feature(req_feature),
    .req_ready(g_req_ready), .tfe_ip_tuple(g_tfe_ip_tuple), .tfe_raw_feature(g_tfe_raw_feature),
    .tfe_ip_valid(g_tfe_ip_valid), .tag_port(g_tag_port), .tag_valid(g_tag_valid),
    .in_flight(g_in_flight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TUPLE_W-1:0] tup(int p);
    return {13{8'(8'hA0 + p)}};
  endfunction

  function automatic logic [FEAT_W-1:0] feat(int p);
    return {32{8'(8'h50 + p)}};
  endfunction

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; stall = 1'b0; req_valid = '0; g_req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    n_cmp++; if (tfe_ip_valid !== 1'b0) begin n_err++; $display("FAIL reset_ipv got %b exp 0", tfe_ip_valid); end
    n_cmp++; if (tfe_ip_tuple !== '0) begin n_err++; $display("FAIL reset_tuple got %h exp 0", tfe_ip_tuple); end
    n_cmp++; if (tag_valid !== 1'b0 || tag_port !== 2'd0) begin n_err++; $display("FAIL reset_tag got %b/%0d exp 0/0", tag_valid, tag_port); end
    n_cmp++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL reset_inflight got %0d exp 0", in_flight); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int peak;
    int k4;
    peak = 0;
    @(negedge clk);
    en = 1'b1; stall = 1'b0; req_valid = 4'hF;
    for (int k = 0; k <= 14; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      k4 = (k + 3) % 4;
      if (k < 8) begin
        n_cmp++; if (req_ready !== 4'(1 << (k % 4))) begin n_err++; $display("FAIL rr_grant k=%0d got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
      end
      n_cmp++; if (tfe_ip_valid !== (k >= 1 && k <= 8)) begin n_err++; $display("FAIL rr_ipv k=%0d got %b", k, tfe_ip_valid); end
      if (k >= 1 && k <= 8) begin
        n_cmp++; if (tfe_ip_tuple !== tup(k4)) begin n_err++; $display("FAIL rr_tuple k=%0d got %h exp %h", k, tfe_ip_tuple, tup(k4)); end
      end
      n_cmp++; if (tag_valid !== (k >= 5 && k <= 12)) begin n_err++; $display("FAIL rr_tagv k=%0d got %b", k, tag_valid); end
      if (k >= 5 && k <= 12) begin
        n_cmp++; if (tag_port !== 2'((k - 5) % 4)) begin n_err++; $display("FAIL rr_tagp k=%0d got %0d exp %0d", k, tag_port, (k - 5) % 4); end
      end
      if (int'(in_flight) > peak) peak = int'(in_flight);
      @(negedge clk);
    end
    n_cmp++; if (peak !== 4) begin n_err++; $display("FAIL rr_peak got %0d exp 4", peak); end
    n_cmp++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL rr_final_inflight got %0d exp 0", in_flight); end
  endtask

  task automatic test_single();
    logic [3:0] exp_if [7];
    exp_if = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
    @(negedge clk);
    en = 1'b1; stall = 1'b0; req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = '0;
      #1;
      n_cmp++; if (tfe_ip_valid !== (k == 1)) begin n_err++; $display("FAIL single_ipv k=%0d got %b", k, tfe_ip_valid); end
      if (k == 1) begin
        n_cmp++; if (tfe_ip_tuple !== tup(2) || tfe_raw_feature !== feat(2)) begin n_err++; $display("FAIL single_data got %h exp %h", tfe_ip_tuple, tup(2)); end
      end
      n_cmp++; if (tag_valid !== (k == 5)) begin n_err++; $display("FAIL single_tagv k=%0d got %b", k, tag_valid); end
      if (k == 5) begin
        n_cmp++; if (tag_port !== 2'd2) begin n_err++; $display("FAIL single_tagp got %0d exp 2", tag_port); end
      end
      n_cmp++; if (in_flight !== exp_if[k]) begin n_err++; $display("FAIL single_inflight k=%0d got %0d exp %0d", k, in_flight, exp_if[k]); end
    end
    n_cmp++; if (tfe_ip_tuple !== tup(2)) begin n_err++; $display("FAIL single_hold got %h exp %h", tfe_ip_tuple, tup(2)); end
  endtask

  task automatic test_gap();
    @(negedge clk);
    en = 1'b1; stall = 1'b0; g_req_valid = 4'b0011;
    for (int k = 0; k <= 6; k++) begin
      if (k == 1) g_req_valid = 4'b0010;
      if (k == 4) g_req_valid = '0;
      #1;
      n_cmp++;
      if (g_req_ready !== ((k == 0) ? 4'b0001 : (k == 3) ? 4'b0010 : 4'b0000)) begin
        n_err++; $display("FAIL gap_ready k=%0d got %b", k, g_req_ready);
      end
      n_cmp++; if (g_tfe_ip_valid !== (k == 1 || k == 4)) begin n_err++; $display("FAIL gap_ipv k=%0d got %b", k, g_tfe_ip_valid); end
      if (k == 4) begin
        n_cmp++; if (g_tfe_ip_tuple !== tup(1)) begin n_err++; $display("FAIL gap_tuple got %h exp %h", g_tfe_ip_tuple, tup(1)); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    en = 1'b1; stall = 1'b0; req_valid = 4'b0010;
    for (int k = 0; k <= 9; k++) begin
      if (k == 1) begin req_valid = 4'b1000; stall = 1'b1; end
      if (k == 7) stall = 1'b0;
      if (k == 8) req_valid = '0;
      #1;
      n_cmp++;
      if (req_ready !== ((k == 0) ? 4'b0010 : (k == 7) ? 4'b1000 : 4'b0000)) begin
        n_err++; $display("FAIL stall_ready k=%0d got %b", k, req_ready);
      end
      n_cmp++; if (tfe_ip_valid !== (k == 1 || k == 8)) begin n_err++; $display("FAIL stall_ipv k=%0d got %b", k, tfe_ip_valid); end
      n_cmp++; if (tag_valid !== (k == 5)) begin n_err++; $display("FAIL stall_tagv k=%0d got %b", k, tag_valid); end
      if (k == 5) begin
        n_cmp++; if (tag_port !== 2'd1) begin n_err++; $display("FAIL stall_tagp got %0d exp 1", tag_port); end
      end
      if (k == 8) begin
        n_cmp++; if (tfe_ip_tuple !== tup(3)) begin n_err++; $display("FAIL stall_tuple got %h exp %h", tfe_ip_tuple, tup(3)); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_en_drop();
    @(negedge clk);
    en = 1'b1; stall = 1'b0; req_valid = 4'hF;
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) en = 1'b0;
      if (k == 7) en = 1'b1;
      if (k == 8) req_valid = '0;
      #1;
      n_cmp++;
      if (req_ready !== ((k == 0) ? 4'b0001 : (k == 1) ? 4'b0010 : (k == 7) ? 4'b0100 : 4'b0000)) begin
        n_err++; $display("FAIL en_ready k=%0d got %b", k, req_ready);
      end
      n_cmp++; if (tfe_ip_valid !== (k == 1 || k == 2 || k == 8)) begin n_err++; $display("FAIL en_ipv k=%0d got %b", k, tfe_ip_valid); end
      if (k == 8) begin
        n_cmp++; if (tfe_ip_tuple !== tup(2)) begin n_err++; $display("FAIL en_tuple got %h exp %h", tfe_ip_tuple, tup(2)); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    en = 1'b1; stall = 1'b0; req_valid = 4'hF;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rstmid_first got %b exp 1000", req_ready); end
    repeat (3) @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    n_cmp++; if (in_flight !== 4'd3) begin n_err++; $display("FAIL rstmid_pre_inflight got %0d exp 3", in_flight); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL rstmid_inflight got %0d exp 0", in_flight); end
    n_cmp++; if (tfe_ip_tuple !== '0 || tfe_raw_feature !== '0 || tfe_ip_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_tfe got %h exp 0", tfe_ip_tuple); end
    n_cmp++; if (tag_valid !== 1'b0 || tag_port !== 2'd0) begin n_err++; $display("FAIL rstmid_tag got %b/%0d exp 0/0", tag_valid, tag_port); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (tag_valid !== 1'b0 || in_flight !== 4'd0) begin n_err++; $display("FAIL rstmid_stale k=%0d got tagv=%b if=%0d", k, tag_valid, in_flight); end
    end
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_restart got %b exp 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    for (int p = 0; p < int'(NP); p++) begin
      req_tuple[p*TUPLE_W +: TUPLE_W] = tup(p);
      req_feature[p*FEAT_W +: FEAT_W] = feat(p);
    end
    test_reset();
    test_round_robin();
    drain();
    test_single();
    drain();
    test_gap();
    drain();
    test_stall();
    drain();
    test_en_drop();
    drain();
    test_reset_mid();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
